// File: rtl/uart_rx_frame.sv
// UART receiver with oversampled mid-bit sampling, runtime baud divisor, selectable
// parity (whole-word or per-byte), one or two stop bits and a valid/ready output.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  parity_per_byte,
    input  logic                  two_stop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                  state_q;
    logic                    rxMeta_q, rxSync_q, rxPrev_q;
    logic [DIV_WIDTH-1:0]    divCnt_q, div_q;
    logic [OS_W-1:0]         osCnt_q;
    logic [BIT_W-1:0]        bitCnt_q;
    logic [DATA_WIDTH-1:0]   dataReg_q, dataOut_q;
    logic                    parEn_q, parOdd_q, perByte_q, twoStop_q;
    logic                    parAcc_q, perrAcc_q, ferrAcc_q, stopCnt_q;
    logic                    valid_q, perr_q, ferr_q, overrun_q;

    logic [DIV_WIDTH-1:0]    divMax;
    logic                    tick, midBit, halfBit, fallEdge, lastBit, byteEnd;

    assign divMax   = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
    assign tick     = (state_q != IDLE) && (divCnt_q == divMax - DIV_WIDTH'(1));
    assign midBit   = tick && (osCnt_q == OS_W'(OVERSAMPLE - 1));
    assign halfBit  = tick && (osCnt_q == OS_W'(OVERSAMPLE / 2 - 1));
    assign fallEdge = rxPrev_q && !rxSync_q;
    assign lastBit  = (bitCnt_q == BIT_W'(DATA_WIDTH - 1));
    assign byteEnd  = (bitCnt_q[2:0] == 3'd7);

    assign data_out   = dataOut_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_in;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            div_q     <= '0;
            osCnt_q   <= '0;
            bitCnt_q  <= '0;
            dataReg_q <= '0;
            dataOut_q <= '0;
            parEn_q   <= 1'b0;
            parOdd_q  <= 1'b0;
            perByte_q <= 1'b0;
            twoStop_q <= 1'b0;
            parAcc_q  <= 1'b0;
            perrAcc_q <= 1'b0;
            ferrAcc_q <= 1'b0;
            stopCnt_q <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end
            if (state_q != IDLE) begin
                divCnt_q <= tick ? '0 : divCnt_q + DIV_WIDTH'(1);
                if (tick) begin
                    osCnt_q <= midBit ? '0 : osCnt_q + OS_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (fallEdge) begin
                        state_q   <= START;
                        divCnt_q  <= '0;
                        osCnt_q   <= '0;
                        div_q     <= baud_div;
                        parEn_q   <= parity_en;
                        parOdd_q  <= parity_odd;
                        perByte_q <= parity_per_byte;
                        twoStop_q <= two_stop;
                    end
                end
                START: begin
                    if (halfBit) begin
                        state_q   <= rxSync_q ? IDLE : DATA;
                        osCnt_q   <= '0;
                        bitCnt_q  <= '0;
                        parAcc_q  <= 1'b0;
                        perrAcc_q <= 1'b0;
                        ferrAcc_q <= 1'b0;
                        stopCnt_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (midBit) begin
                        dataReg_q <= {rxSync_q, dataReg_q[DATA_WIDTH-1:1]};
                        parAcc_q  <= parAcc_q ^ rxSync_q;
                        bitCnt_q  <= bitCnt_q + BIT_W'(1);
                        if (parEn_q && perByte_q && byteEnd) begin
                            state_q <= PARITY;
                        end else if (lastBit) begin
                            state_q <= parEn_q ? PARITY : STOP;
                        end
                    end
                end
                // parAcc_q holds the XOR of every data bit since the previous parity bit,
                // which is the current byte or the whole word depending on the mode.
                PARITY: begin
                    if (midBit) begin
                        if (rxSync_q != (parAcc_q ^ parOdd_q)) begin
                            perrAcc_q <= 1'b1;
                        end
                        parAcc_q <= 1'b0;
                        state_q  <= (bitCnt_q == BIT_W'(DATA_WIDTH)) ? STOP : DATA;
                    end
                end
                STOP: begin
                    if (midBit) begin
                        if (!rxSync_q) begin
                            ferrAcc_q <= 1'b1;
                        end
                        if (twoStop_q && !stopCnt_q) begin
                            stopCnt_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (!valid_q || data_ready) begin
                        dataOut_q <= dataReg_q;
                        perr_q    <= perrAcc_q;
                        ferr_q    <= ferrAcc_q;
                        valid_q   <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
